// File: rtl/mux_41_rr_if.sv
// Stream bundle for the 4-to-1 round-robin merger: four valid/ready input lanes,
// one registered output beat tagged with its source lane, plus priority status.
interface mux_41_rr_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_sel;
  logic                out_ready;
  logic [1:0]          rr_ptr;

  // Environment side: produces input lanes, consumes the merged stream.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready,
    input  rr_ptr
  );

  // Merger side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready,
    output rr_ptr
  );
endinterface

// File: rtl/mux_41_rr.sv
// 4-to-1 stream merger with round-robin arbitration into a one-entry output register.
// Each beat carries its source lane index so a downstream demux can route it back.
module mux_41_rr #(
  parameter int unsigned DATA_W = 8
) (
  input logic         clk,
  input logic         rst,
  mux_41_rr_if.slave  bus
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_sel_q, out_sel_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;

  logic              can_load;
  logic              found;
  logic [1:0]        grant;
  logic [1:0]        idx;
  logic [3:0]        ready;
  logic              xfer;
  logic [DATA_W-1:0] chan_data [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      chan_data[k] = bus.in_data[k*DATA_W +: DATA_W];
    end
  end

  // A stalled output register blocks every lane; a draining one can refill in the same cycle.
  assign can_load = !out_valid_q || bus.out_ready;

  // First valid lane searching upward from rr_ptr, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    grant = rr_ptr_q;
    idx   = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    ready = 4'b0000;
    if (found && can_load && !rst) begin
      ready = 4'b0001 << grant;
    end
  end

  assign xfer = |(bus.in_valid & ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = chan_data[grant];
      out_sel_d   = grant;
      rr_ptr_d    = grant + 2'd1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      rr_ptr_q    <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_mux_41_rr.sv
// Bench for mux_41_rr: directed scenarios then protocol-respecting random traffic,
// all checked cycle by cycle against a beat-level reference model.
module tb_mux_41_rr;

  localparam int unsigned DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  mux_41_rr_if #(.DATA_W(DATA_W)) bus ();

  mux_41_rr #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: the held beat and the lane with top priority.
  bit       m_valid;
  int       m_data;
  int       m_sel;
  int       m_ptr;
  bit [3:0] last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lane_data(input int k);
    lane_data = int'(bus.in_data[k*DATA_W +: DATA_W]);
  endfunction

  // Lane that would win this cycle, or -1 when nothing may be accepted.
  function automatic int model_winner();
    int w;
    w = -1;
    if (!rst && (!m_valid || bus.out_ready)) begin
      for (int i = 3; i >= 0; i--) begin
        if (bus.in_valid[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
      end
    end
    model_winner = w;
  endfunction

  // Inputs are already driven; check the combinational ready, clock, then check the register.
  task automatic cycle();
    int w;
    logic [3:0] exp_ready;
    #1;
    w = model_winner();
    exp_ready = (w < 0) ? 4'b0000 : 4'(1 << w);
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    last_acc = bus.in_valid & exp_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 0;
      m_sel   = 0;
      m_ptr   = 0;
    end else if (w >= 0) begin
      m_valid = 1'b1;
      m_data  = lane_data(w);
      m_sel   = w;
      m_ptr   = (w + 1) % 4;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    check("out_sel", 32'(bus.out_sel), 32'(m_sel));
    check("rr_ptr", 32'(bus.rr_ptr), 32'(m_ptr));
  endtask

  task automatic drive(input logic [3:0] v, input logic ordy);
    bus.in_valid  = v;
    bus.out_ready = ordy;
  endtask

  initial begin
    m_valid = 1'b0;
    m_data  = 0;
    m_sel   = 0;
    m_ptr   = 0;
    last_acc = '0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset then single request from lane 2.
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    bus.in_data[2*DATA_W +: DATA_W] = 8'hA5;
    drive(4'b0100, 1'b1);
    #1;
    check("single_ready", 32'(bus.in_ready), 32'h4);
    cycle();
    check("single_data", 32'(bus.out_data), 32'hA5);
    check("single_sel", 32'(bus.out_sel), 32'd2);
    check("single_ptr", 32'(bus.rr_ptr), 32'd3);

    // Round-robin at full load from a fresh priority pointer.
    rst = 1'b1;
    drive(4'b0000, 1'b1);
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) bus.in_data[k*DATA_W +: DATA_W] = 8'(8'h10 + k);
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rr_sel", 32'(bus.out_sel), 32'(i % 4));
      check("rr_data", 32'(bus.out_data), 32'(8'h10 + (i % 4)));
      check("rr_valid", 32'(bus.out_valid), 32'd1);
    end

    // Wrap and skip: grant lane 2 (ptr -> 3), then only lanes 0 and 1 request.
    drive(4'b0100, 1'b1);
    cycle();
    drive(4'b0011, 1'b1);
    cycle();
    check("wrap_sel", 32'(bus.out_sel), 32'd0);
    check("wrap_ptr", 32'(bus.rr_ptr), 32'd1);
    drive(4'b0010, 1'b1);
    cycle();
    check("skip_sel", 32'(bus.out_sel), 32'd1);

    // Backpressure with lane 1 held.
    drive(4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_sel", 32'(bus.out_sel), 32'd1);
      check("bp_ptr", 32'(bus.rr_ptr), 32'd2);
    end
    drive(4'b1111, 1'b1);
    cycle();
    check("bp_release_sel", 32'(bus.out_sel), 32'd2);
    check("bp_release_data", 32'(bus.out_data), 32'h12);

    // Idle cycles must not rotate priority.
    drive(4'b0001, 1'b1);
    cycle();
    check("idle_grant0", 32'(bus.out_sel), 32'd0);
    drive(4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) cycle();
    drive(4'b1111, 1'b1);
    cycle();
    check("idle_next_sel", 32'(bus.out_sel), 32'd1);

    // Reset in the middle of a stall.
    drive(4'b0001, 1'b1);
    cycle();
    drive(4'b1111, 1'b0);
    cycle();
    rst = 1'b1;
    #1;
    check("rst_stall_ready", 32'(bus.in_ready), 32'd0);
    cycle();
    rst = 1'b0;
    check("rst_stall_valid", 32'(bus.out_valid), 32'd0);
    check("rst_stall_ptr", 32'(bus.rr_ptr), 32'd0);

    // Random traffic: a lane keeps its beat until accepted, then may offer a new one.
    last_acc = '0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!bus.in_valid[k] || last_acc[k]) begin
          bus.in_valid[k] = ($urandom_range(0, 2) != 0);
          bus.in_data[k*DATA_W +: DATA_W] = 8'($urandom);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
